// File: rtl/ifu_fetch_queue.sv
// rtl/ifu_fetch_queue.sv - {pc, instr} queue between instruction fetch and decode.
// Optional FQ_BYPASS_EN: zero-latency pass-through when the queue is empty.
module ifu_fetch_queue #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [63:0]      head_data;
  logic             stored;
  logic             push;
  logic             wr;
  logic             pop;

  // Full/empty come only from count; head == tail is ambiguous.
  assign stored    = (count != '0);
  assign in_ready  = (count != FULL);
  assign push      = in_valid & in_ready;
  assign pop       = stored & out_ready;
  assign head_data = mem[head];

`ifdef FQ_BYPASS_EN
  logic bypass;

  assign bypass    = ~stored & in_valid & ~flush;
  assign out_valid = stored | bypass;
  // A bypassed entry taken by decode in the same cycle never touches storage.
  assign wr        = push & ~(bypass & out_ready);

  always_comb begin
    out_pc    = '0;
    out_instr = '0;
    if (bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end else if (stored) begin
      out_pc    = head_data[63:32];
      out_instr = head_data[31:0];
    end
  end
`else
  assign out_valid = stored;
  assign wr        = push;
  assign out_pc    = stored ? head_data[63:32] : '0;
  assign out_instr = stored ? head_data[31:0]  : '0;
`endif

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({wr, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && wr) begin
      mem[tail] <= {in_pc, in_instr};
    end
  end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// tb/tb_ifu_fetch_queue.sv - table-driven self-checking bench for ifu_fetch_queue.
module tb_ifu_fetch_queue;

`ifdef FQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;

  ifu_fetch_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        ordy;
    logic [2:0]  cnt;
    logic        ov;
    logic        ir;
    logic [31:0] opc;
    logic [31:0] oins;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic rst, input logic fl, input logic iv,
                              input logic [31:0] pc, input logic [31:0] ins,
                              input logic ordy, input int cnt, input logic ov,
                              input logic ir, input logic [31:0] opc,
                              input logic [31:0] oins);
    vec_t t;
    t.rst = rst; t.fl = fl; t.iv = iv; t.pc = pc; t.ins = ins; t.ordy = ordy;
    t.cnt = 3'(cnt); t.ov = ov; t.ir = ir; t.opc = opc; t.oins = oins;
    vq.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked after the rising
  // edge with in_valid dropped so the bypass path cannot colour the result.
  task automatic apply(input vec_t t);
    @(negedge clk);
    reset = t.rst; flush = t.fl; in_valid = t.iv;
    in_pc = t.pc; in_instr = t.ins; out_ready = t.ordy;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset for two cycles, then idle.
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Fill with decode stalled, one push refused while full.
    for (int k = 0; k < 4; k++)
      add(0, 0, 1, 32'h3000 + 32'(4 * k), 32'h3C01_0001 + 32'(k), 0,
          k + 1, 1, k != 3, 32'h3000, 32'h3C01_0001);
    add(0, 0, 1, 32'h3010, 32'h3C01_0005, 0, 4, 1, 0, 32'h3000, 32'h3C01_0001);
    // Drain in order.
    for (int k = 0; k < 4; k++)
      add(0, 0, 0, 0, 0, 1, 3 - k, k != 3, 1,
          (k == 3) ? 32'h0 : 32'h3004 + 32'(4 * k),
          (k == 3) ? 32'h0 : 32'h3C01_0002 + 32'(k));
    // Streaming for 10 cycles: pointers wrap twice.
    for (int k = 0; k < 10; k++)
      add(0, 0, 1, 32'h3000 + 32'(4 * k), 32'h3C02_0000 + 32'(k), 1,
          BYP ? 0 : 1, !BYP, 1,
          BYP ? 32'h0 : 32'h3000 + 32'(4 * k),
          BYP ? 32'h0 : 32'h3C02_0000 + 32'(k));
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    // Full plus pop: pop happens, push refused, then accepted next cycle.
    for (int k = 0; k < 4; k++)
      add(0, 0, 1, 32'h5000 + 32'(4 * k), 32'h5A00_0001 + 32'(k), 0,
          k + 1, 1, k != 3, 32'h5000, 32'h5A00_0001);
    add(0, 0, 1, 32'h5010, 32'h5A00_0005, 1, 3, 1, 1, 32'h5004, 32'h5A00_0002);
    add(0, 0, 1, 32'h5010, 32'h5A00_0005, 0, 4, 1, 0, 32'h5004, 32'h5A00_0002);
    for (int k = 0; k < 4; k++)
      add(0, 0, 0, 0, 0, 1, 3 - k, k != 3, 1,
          (k == 3) ? 32'h0 : 32'h5008 + 32'(4 * k),
          (k == 3) ? 32'h0 : 32'h5A00_0003 + 32'(k));
    // Flush mid-stream with a push and pop in the flush cycle.
    for (int k = 0; k < 3; k++)
      add(0, 0, 1, 32'h3000 + 32'(4 * k), 32'h3C01_0001 + 32'(k), 0,
          k + 1, 1, 1, 32'h3000, 32'h3C01_0001);
    add(0, 1, 1, 32'h4000, 32'h0800_1000, 1, 0, 0, 1, 0, 0);
    add(0, 0, 1, 32'h4000, 32'h0800_1000, 0, 1, 1, 1, 32'h4000, 32'h0800_1000);
    add(0, 0, 1, 32'h4004, 32'h0800_1001, 0, 2, 1, 1, 32'h4000, 32'h0800_1000);
    // Reset wins over flush and backpressure.
    add(1, 1, 1, 32'h4008, 32'h0800_1002, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 32'h6000, 32'h2406_0006, 0, 1, 1, 1, 32'h6000, 32'h2406_0006);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i]);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vq[i].cnt));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vq[i].ov));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vq[i].ir));
      chk($sformatf("v%0d_out_pc", i), out_pc, vq[i].opc);
      chk($sformatf("v%0d_out_instr", i), out_instr, vq[i].oins);
    end

    // Stalled full queue: head stays put while upstream inputs churn.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      reset = 0; flush = 0; out_ready = 0; in_valid = 1;
      in_pc = 32'h7000 + 32'(4 * k); in_instr = 32'h7700_0000 + 32'(k);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1; in_pc = $urandom; in_instr = $urandom; out_ready = 0;
      #1;
      chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'h0);
      chk($sformatf("stall%0d_out_pc", k), out_pc, 32'h7000);
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d_count", k), 32'(count), 32'h4);
      chk($sformatf("stall%0d_out_instr", k), out_instr, 32'h7700_0000);
    end
    @(negedge clk);
    out_ready = 1; in_valid = 1;
    #1;
    chk("full_ready_indep", 32'(in_ready), 32'h0);
    chk("full_out_valid", 32'(out_valid), 32'h1);
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0; in_valid = 0; out_ready = 0;
    #1;
    chk("flush_full_count", 32'(count), 32'h0);

`ifdef FQ_BYPASS_EN
    @(negedge clk);
    in_valid = 1; in_pc = 32'h3010; in_instr = 32'h3C01_0005; out_ready = 1;
    #1;
    chk("byp_out_valid", 32'(out_valid), 32'h1);
    chk("byp_out_pc", out_pc, 32'h3010);
    chk("byp_out_instr", out_instr, 32'h3C01_0005);
    @(posedge clk);
    #1;
    chk("byp_consumed_count", 32'(count), 32'h0);
    @(negedge clk);
    in_valid = 1; in_pc = 32'h3014; in_instr = 32'h3C01_0006; out_ready = 0;
    #1;
    chk("byp_stall_out_pc", out_pc, 32'h3014);
    @(posedge clk);
    #1;
    in_valid = 0;
    #1;
    chk("byp_stall_count", 32'(count), 32'h1);
    chk("byp_stall_head", out_pc, 32'h3014);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_queue.md
Name: ifu_fetch_queue

Overview:
- Instruction fetch queue between the instruction fetch unit and the decode stage.
- Buffers {pc, instr} pairs with a valid/ready handshake on both sides, so decode stalls do not need to freeze PC.
- Discards all buffered entries on a flush when the fetch unit redirects to a jump/branch target.
- Circular buffer with registered head/tail pointers and an occupancy counter.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high; clears queue
- flush  input  1  synchronous discard of all entries (jump/branch redirect)
- in_valid  input  1  fetch side presents an entry
- in_ready  output  1  queue accepts an entry this cycle
- in_pc  input  32  PC of the incoming instruction
- in_instr  input  32  incoming instruction word
- out_valid  output  1  head entry is available to decode
- out_ready  input  1  decode consumes the head this cycle
- out_pc  output  32  PC of the head entry
- out_instr  output  32  head instruction word
- count  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Clocking and reset: clock clk; reset is synchronous and active-high.
- Reset values:
  - head = tail = 0, count = 0.
  - out_valid = 0, in_ready = 1, out_pc = 0, out_instr = 0.
  - Storage array is not reset.
- Push: push = in_valid & in_ready.
  - On push, {in_pc, in_instr} is written to mem[tail].
  - tail <= tail + 1, wrapping modulo DEPTH.
- Pop: pop = out_valid & out_ready.
  - head <= head + 1, wrapping modulo DEPTH.
- in_ready = (count != DEPTH).
  - A full queue does not accept a push in the same cycle as a pop.
  - This keeps in_ready independent of out_ready, with no combinational path.
- out_valid = (count != 0).
  - out_pc and out_instr come from mem[head] when valid.
  - Both are forced to 0 when out_valid = 0.
- Count update:
  - push only: count + 1.
  - pop only: count - 1.
  - push and pop together: count unchanged, both pointers advance.
  - Simultaneous push and pop is legal at any count from 1 to DEPTH-1.
- Latency: an entry pushed in cycle N appears at the output in cycle N+1 at the earliest; throughput is 1 entry/cycle.
- Priority order is reset > flush > push/pop.
  - flush sets head = tail = 0 and count = 0 at the next edge.
  - A push or pop in the flush cycle is ignored; the redirected fetch arrives in the following cycle.
- Reset or flush mid-stream: any in-flight handshake in that cycle is dropped, and no partial state survives.
- Input stability: in_pc and in_instr are sampled only on push. The upstream side may change them freely while in_ready = 0.
- Output stability: while out_valid = 1 and out_ready = 0, out_pc and out_instr are stable until a pop, flush or reset.
- Wrap-around: pointers roll over from DEPTH-1 to 0. Full versus empty is decided only by count, never by pointer equality.

Optional Feature:
- Macro: FQ_BYPASS_EN
- Defined: when count = 0, in_valid = 1 and flush = 0:
  - out_valid = 1 combinationally, with out_pc = in_pc and out_instr = in_instr.
  - If out_ready = 1 in that cycle, the entry is consumed directly: not written, pointers and count unchanged.
  - If out_ready = 0, the entry is written normally, giving count = 1.
  - Zero-cycle latency through an empty queue.
- Not defined: no input-to-output combinational path; minimum latency is 1 cycle as above.

Test Plan:
- Reset then idle: assert reset 2 cycles, then no traffic -> count = 0, out_valid = 0, in_ready = 1, out_pc = 0, out_instr = 0.
- Fill and drain with out_ready = 0:
  - Push pc 0x3000/0x3004/0x3008/0x300C with instr 0x3C010001..0x3C010004 -> count = 4, in_ready = 0.
  - Then out_ready = 1 for 4 cycles -> outputs appear in order 0x3000..0x300C; count returns to 0.
- Streaming: in_valid = out_ready = 1 for 10 cycles with pc stepping +4 from 0x3000 -> after the first cycle, one output per cycle in order; count stays 1 (0 with FQ_BYPASS_EN); pointers wrap twice.
- Full plus pop: with count = 4, drive in_valid = 1 and out_ready = 1 -> the pop occurs, no push is accepted, count = 3; the next cycle accepts the push.
- Flush mid-stream:
  - With count = 3 (head pc 0x3000), assert flush together with in_valid carrying pc 0x4000 -> next cycle count = 0 and out_valid = 0.
  - The following push of pc 0x4000 becomes head with out_pc = 0x4000.
- Reset over flush and backpressure: with count = 2 and out_ready = 0, assert reset and flush together -> count = 0 and in_ready = 1 next cycle.
  - With FQ_BYPASS_EN defined: in_valid of pc 0x3010 into an empty queue gives out_pc = 0x3010 in the same cycle.
